// File: rtl/path_sequencer_if.sv
// Node handshake between the path sequencer (master) and the motion controller (slave).
interface path_sequencer_if #(
   parameter int NODE_W = 8
);
   logic              node_valid;
   logic [NODE_W-1:0] node_out;
   logic [3:0]        node_idx;
   logic              node_ready;
   logic              arrived;

   modport master (
      output node_valid, node_out, node_idx,
      input  node_ready, arrived
   );

   modport slave (
      input  node_valid, node_out, node_idx,
      output node_ready, arrived
   );
endinterface

// File: rtl/path_sequencer.sv
// Latches the planned path on a cpu_done rising edge, issues one node at a time to the
// motion controller, waits for arrival with a timeout, then requests a data-memory clear.
module path_sequencer #(
   parameter int MAX_NODES = 13,
   parameter int NODE_W    = 8,
   parameter int TIMEOUT   = 1000000,
   parameter int TMR_W     = 20
) (
   input  logic              adc_sck,
   input  logic              reset,
   input  logic              cpu_done,
   input  logic [NODE_W-1:0] path0,
   input  logic [NODE_W-1:0] path1,
   input  logic [NODE_W-1:0] path2,
   input  logic [NODE_W-1:0] path3,
   input  logic [NODE_W-1:0] path4,
   input  logic [NODE_W-1:0] path5,
   input  logic [NODE_W-1:0] path6,
   input  logic [NODE_W-1:0] path7,
   input  logic [NODE_W-1:0] path8,
   input  logic [NODE_W-1:0] path9,
   input  logic [NODE_W-1:0] path10,
   input  logic [NODE_W-1:0] path11,
   input  logic [NODE_W-1:0] path12,
   input  logic [7:0]        index,
   path_sequencer_if.master  mc,
   output logic              busy,
   output logic              path_done,
   output logic              mem_clear_req,
   output logic              fault
);

   localparam int NPORTS = 13;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      TRAVEL,
      DONE,
      FAULT
   } state_t;

   state_t            state_q, state_d;
   logic              cpu_done_q;
   logic [NODE_W-1:0] path_q [NPORTS];
   logic [NODE_W-1:0] path_in [NPORTS];
   logic [3:0]        len_q, len_d;
   logic [3:0]        ptr_q, ptr_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              path_done_q;
   logic              start;

   assign path_in = '{path0, path1, path2, path3, path4, path5, path6,
                      path7, path8, path9, path10, path11, path12};

   // Edge detect; cpu_done_q resets low so a level held across reset replays the path.
   assign start = cpu_done & ~cpu_done_q;

   always_ff @(posedge adc_sck or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cpu_done_q  <= 1'b0;
         path_q      <= '{default: '0};
         len_q       <= '0;
         ptr_q       <= '0;
         timer_q     <= '0;
         path_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpu_done_q  <= cpu_done;
         len_q       <= len_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         path_done_q <= (state_d == DONE) && (state_q != DONE);
         if (state_q == LOAD) begin
            path_q <= path_in;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            len_d   = (index > 8'(MAX_NODES)) ? 4'(MAX_NODES) : index[3:0];
            ptr_d   = '0;
            state_d = (len_d == '0) ? DONE : ISSUE;
         end
         ISSUE: begin
            timer_d = '0;
            if (mc.node_ready) state_d = TRAVEL;
         end
         TRAVEL: begin
            timer_d = timer_q + 1'b1;
            // Arrival takes priority over a timeout expiring in the same cycle.
            if (mc.arrived) begin
               if (ptr_q == len_q - 4'd1) begin
                  state_d = DONE;
               end else begin
                  ptr_d   = ptr_q + 4'd1;
                  state_d = ISSUE;
               end
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d = FAULT;
            end
         end
         DONE: begin
            if (!cpu_done) state_d = IDLE;
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mc.node_valid = (state_q == ISSUE);
   assign mc.node_out   = (state_q == ISSUE) ? path_q[ptr_q] : '0;
   assign mc.node_idx   = ((state_q == ISSUE) || (state_q == TRAVEL)) ? ptr_q : '0;
   assign busy          = (state_q != IDLE) && (state_q != FAULT);
   assign path_done     = path_done_q;
   assign mem_clear_req = (state_q == DONE);
   assign fault         = (state_q == FAULT);

endmodule

// File: tb/tb_path_sequencer.sv
// Directed scoreboard bench for path_sequencer: expected nodes are queued by the stimulus
// and popped by a monitor on every valid/ready transfer.
module tb_path_sequencer;

   logic       clk;
   logic       reset;
   logic       cpu_done;
   logic [7:0] path [13];
   logic [7:0] index;
   logic       busy, path_done, mem_clear_req, fault;

   path_sequencer_if #(.NODE_W(8)) bus ();

   path_sequencer #(.TIMEOUT(8)) dut (
      .adc_sck       (clk),
      .reset         (reset),
      .cpu_done      (cpu_done),
      .path0         (path[0]),
      .path1         (path[1]),
      .path2         (path[2]),
      .path3         (path[3]),
      .path4         (path[4]),
      .path5         (path[5]),
      .path6         (path[6]),
      .path7         (path[7]),
      .path8         (path[8]),
      .path9         (path[9]),
      .path10        (path[10]),
      .path11        (path[11]),
      .path12        (path[12]),
      .index         (index),
      .mc            (bus),
      .busy          (busy),
      .path_done     (path_done),
      .mem_clear_req (mem_clear_req),
      .fault         (fault)
   );

   typedef struct packed {
      logic [3:0] idx;
      logic [7:0] node;
   } exp_t;

   exp_t exp_q [$];
   int   checks   = 0;
   int   errors   = 0;
   int   pd_count = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input logic [7:0] node);
      exp_t e;
      e.idx  = 4'(idx);
      e.node = node;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(bus.node_valid), 0);
      check({tag, "_node_out"}, 32'(bus.node_out), 0);
      check({tag, "_node_idx"}, 32'(bus.node_idx), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_path_done"}, 32'(path_done), 0);
      check({tag, "_mem_clear"}, 32'(mem_clear_req), 0);
      check({tag, "_fault"}, 32'(fault), 0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.node_valid && n < 60) begin
         tick();
         n++;
      end
      check("wait_node_valid", 32'(bus.node_valid), 1);
   endtask

   // Assumes node_ready is high: transfer on the next edge, arrival `delay` edges later.
   task automatic run_node(input int delay);
      wait_valid();
      tick();
      repeat (delay) tick();
      bus.arrived = 1'b1;
      tick();
      bus.arrived = 1'b0;
   endtask

   task automatic run_path(input int n, input int delay);
      for (int i = 0; i < n; i++) run_node(delay);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.node_valid && bus.node_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_transfer: got node %0d idx %0d expected none", bus.node_out, bus.node_idx);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_node_out", 32'(bus.node_out), 32'(e.node));
               check("sb_node_idx", 32'(bus.node_idx), 32'(e.idx));
            end
         end
         if (path_done) pd_count++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stable;
      reset          = 1'b1;
      cpu_done       = 1'b0;
      index          = '0;
      bus.node_ready = 1'b0;
      bus.arrived    = 1'b0;
      for (int i = 0; i < 13; i++) path[i] = '0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Three-node path with start latency checks.
      path[0] = 8'd5; path[1] = 8'd9; path[2] = 8'd2;
      for (int i = 3; i < 13; i++) path[i] = 8'(100 + i);
      index = 8'd3;
      bus.node_ready = 1'b1;
      push(0, 8'd5); push(1, 8'd9); push(2, 8'd2);
      cpu_done = 1'b1;
      tick();
      check("load_busy", 32'(busy), 1);
      check("load_valid", 32'(bus.node_valid), 0);
      tick();
      check("issue_valid", 32'(bus.node_valid), 1);
      run_path(3, 5);
      check("t1_path_done", 32'(path_done), 1);
      check("t1_mem_clear", 32'(mem_clear_req), 1);
      tick();
      check("t1_path_done_pulse", 32'(path_done), 0);
      repeat (3) tick();
      check("t1_mem_clear_held", 32'(mem_clear_req), 1);
      cpu_done = 1'b0;
      tick();
      check("t1_mem_clear_off", 32'(mem_clear_req), 0);
      check("t1_idle_busy", 32'(busy), 0);
      check("t1_pd_count", 32'(pd_count), 1);

      // Stall in ISSUE; path inputs and arrived change underneath and must be ignored.
      path[0] = 8'd5; path[1] = 8'd7; index = 8'd2;
      bus.node_ready = 1'b0;
      push(0, 8'd5); push(1, 8'd7);
      cpu_done = 1'b1;
      wait_valid();
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin path[0] = 8'hEE; path[1] = 8'hEF; index = 8'd9; end
         if (i == 5) bus.arrived = 1'b1;
         if (i == 6) bus.arrived = 1'b0;
         tick();
         stable = stable && bus.node_valid && (bus.node_out == 8'd5) && (bus.node_idx == 4'd0);
      end
      check("t2_stall_stable", 32'(stable), 1);
      bus.node_ready = 1'b1;
      run_path(2, 3);
      check("t2_path_done", 32'(path_done), 1);
      cpu_done = 1'b0;
      tick();
      check("t2_pd_count", 32'(pd_count), 2);

      // Empty path: DONE two edges after the start edge, no node issued.
      index = 8'd0;
      cpu_done = 1'b1;
      tick();
      check("t3_load_pd", 32'(path_done), 0);
      tick();
      check("t3_path_done", 32'(path_done), 1);
      check("t3_valid", 32'(bus.node_valid), 0);
      check("t3_mem_clear", 32'(mem_clear_req), 1);
      cpu_done = 1'b0;
      tick();
      check("t3_idle_busy", 32'(busy), 0);
      check("t3_pd_count", 32'(pd_count), 3);

      // Oversized index clamps to 13 nodes.
      index = 8'd20;
      for (int i = 0; i < 13; i++) begin
         path[i] = 8'(20 + i);
         push(i, 8'(20 + i));
      end
      cpu_done = 1'b1;
      run_path(13, 1);
      check("t4_path_done", 32'(path_done), 1);
      check("t4_valid", 32'(bus.node_valid), 0);
      cpu_done = 1'b0;
      tick();
      check("t4_pd_count", 32'(pd_count), 4);

      // Arrival coincident with the final timeout cycle wins.
      index = 8'd2; path[0] = 8'd3; path[1] = 8'd4;
      push(0, 8'd3); push(1, 8'd4);
      cpu_done = 1'b1;
      run_path(2, 7);
      check("t5a_path_done", 32'(path_done), 1);
      check("t5a_fault", 32'(fault), 0);
      cpu_done = 1'b0;
      tick();
      check("t5a_pd_count", 32'(pd_count), 5);

      // No arrival: fault after the 8th TRAVEL cycle, sticky across new starts.
      index = 8'd1; path[0] = 8'd6;
      push(0, 8'd6);
      cpu_done = 1'b1;
      wait_valid();
      tick();
      repeat (7) tick();
      check("t5b_pre_fault", 32'(fault), 0);
      check("t5b_pre_busy", 32'(busy), 1);
      tick();
      check("t5b_fault", 32'(fault), 1);
      check("t5b_busy", 32'(busy), 0);
      check("t5b_valid", 32'(bus.node_valid), 0);
      bus.arrived = 1'b1;
      tick();
      bus.arrived = 1'b0;
      cpu_done = 1'b0;
      tick();
      cpu_done = 1'b1;
      repeat (4) tick();
      check("t5b_sticky_fault", 32'(fault), 1);
      check("t5b_sticky_valid", 32'(bus.node_valid), 0);
      check("t5b_sticky_busy", 32'(busy), 0);

      // Reset in TRAVEL of node 1 with cpu_done held: abort, then replay from node 0.
      path[0] = 8'd11; path[1] = 8'd12; path[2] = 8'd13; index = 8'd3;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      push(0, 8'd11); push(1, 8'd12);
      run_node(2);
      wait_valid();
      tick();
      tick();
      check("t6_travel_busy", 32'(busy), 1);
      check("t6_travel_idx", 32'(bus.node_idx), 1);
      reset = 1'b1;
      #1;
      check_all_zero("t6_abort");
      tick();
      tick();
      reset = 1'b0;
      push(0, 8'd11); push(1, 8'd12); push(2, 8'd13);
      run_path(3, 2);
      check("t6_path_done", 32'(path_done), 1);
      cpu_done = 1'b0;
      tick();
      check("t6_pd_count", 32'(pd_count), 6);
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
